// File: rtl/ws2812_pkg.sv
// Shared WS2812B timing, pulse/state encodings and pixel layout for the LED transmit and receive paths.
package ws2812_pkg;

    localparam real T0H           = 0.40e-6;
    localparam real T1H           = 0.80e-6;
    localparam real T_BIT         = 1.25e-6;
    localparam real T_RESET       = 50.0e-6;
    localparam real T_MIN_HIGH    = 0.15e-6;
    localparam real T_THRESH_HIGH = 0.60e-6;
    localparam real T_MAX_HIGH    = 1.50e-6;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PIX_W     = 24;
    localparam int unsigned BIT_CNT_W = 5;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    typedef enum logic [1:0] {PULSE_GLITCH, PULSE_ZERO, PULSE_ONE, PULSE_ERROR} pulse_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Tiny bias keeps exact .5 products (e.g. 1.5us at 27MHz) from rounding down.
    function automatic int unsigned sec2cyc(input real t, input int unsigned clk_hz);
        return $rtoi(t * real'(clk_hz) + 0.5 + 1.0e-6);
    endfunction

    // Wire order is G,R,B; pixel payload is {R,G,B}.
    function automatic rgb_t wire_to_rgb(input logic [PIX_W-1:0] w);
        rgb_t p;
        p.g = w[23:16];
        p.r = w[15:8];
        p.b = w[7:0];
        return p;
    endfunction

endpackage

// File: rtl/ws2812_receiver_if.sv
// Serial input and decoded-pixel outputs of the WS2812B receiver.
interface ws2812_receiver_if;
    import ws2812_pkg::*;

    logic din;
    rgb_t rgb_data;
    logic rgb_valid;
    logic frame_end;
    logic bit_error;
    logic busy;
    logic dout;

    modport master (output din, input rgb_data, rgb_valid, frame_end, bit_error, busy, dout);
    modport slave  (input din, output rgb_data, rgb_valid, frame_end, bit_error, busy, dout);

endinterface

// File: rtl/ws2812_pulse_meter.sv
// Synchronises din, measures high/low run lengths and classifies each high pulse.
module ws2812_pulse_meter
    import ws2812_pkg::*;
#(
    parameter int unsigned MIN_HIGH     = 4,
    parameter int unsigned THRESH_HIGH  = 16,
    parameter int unsigned MAX_HIGH     = 41,
    parameter int unsigned RESET_CYCLES = 1350
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   din_i,
    output logic   din_s_o,
    output logic   rise_c_o,
    output logic   pulse_stb_c_o,
    output pulse_t pulse_code_c_o,
    output logic   gap_c_o
);

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_HIGH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(RESET_CYCLES - 1);

    logic             meta_q, din_s_q, lvl_q;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic             fall_c, at_max_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    // Run-length counters: each holds the length of the current run of its level.
    always_comb begin
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        if (din_s_q) begin
            high_cnt_d = lvl_q ? sat_inc(high_cnt_q) : CNT_W'(1);
            low_cnt_d  = '0;
        end else begin
            low_cnt_d  = lvl_q ? CNT_W'(1) : sat_inc(low_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q     <= 1'b0;
            din_s_q    <= 1'b0;
            lvl_q      <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            meta_q     <= din_i;
            din_s_q    <= meta_q;
            lvl_q      <= din_s_q;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
        end
    end

    // Over-long highs strobe once, the cycle the count reaches MAX_HIGH.
    always_comb begin
        fall_c         = ~din_s_q & lvl_q;
        at_max_c       = lvl_q & (high_cnt_q == MAX_C);
        rise_c_o       = din_s_q & ~lvl_q;
        pulse_stb_c_o  = at_max_c | (fall_c & (high_cnt_q < MAX_C));
        pulse_code_c_o = PULSE_ZERO;
        if (high_cnt_q >= MAX_C) begin
            pulse_code_c_o = PULSE_ERROR;
        end else if (high_cnt_q < MIN_C) begin
            pulse_code_c_o = PULSE_GLITCH;
        end else if (high_cnt_q >= THRESH_C) begin
            pulse_code_c_o = PULSE_ONE;
        end
        gap_c_o = ~din_s_q & (low_cnt_q == GAP_C);
    end

    assign din_s_o = din_s_q;

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812B receiver: decodes the first pixel of each frame and forwards the rest of the stream.
module ws2812_receiver
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter real         RESET_TIME = 50.0e-6
) (
    input logic              clk,
    input logic              rst,
    ws2812_receiver_if.slave bus
);

    localparam int unsigned MIN_HIGH     = sec2cyc(T_MIN_HIGH, CLK_FREQ);
    localparam int unsigned THRESH_HIGH  = sec2cyc(T_THRESH_HIGH, CLK_FREQ);
    localparam int unsigned MAX_HIGH     = sec2cyc(T_MAX_HIGH, CLK_FREQ);
    localparam int unsigned RESET_CYCLES = sec2cyc(RESET_TIME, CLK_FREQ);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PIX_W - 1);

    logic   din_s, rise_c, pulse_stb_c, gap_c, data_bit_c;
    pulse_t pulse_code_c;

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 consumed_q, consumed_d;
    logic [PIX_W-2:0]     shift_q, shift_d;
    rgb_t                 rgb_q, rgb_d;
    logic                 valid_q, valid_d;
    logic                 frame_end_q, frame_end_d;
    logic                 bit_error_q, bit_error_d;
    logic                 busy_q, busy_d;
    logic                 dout_q, dout_d;

    ws2812_pulse_meter #(
        .MIN_HIGH     (MIN_HIGH),
        .THRESH_HIGH  (THRESH_HIGH),
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_meter (
        .clk            (clk),
        .rst            (rst),
        .din_i          (bus.din),
        .din_s_o        (din_s),
        .rise_c_o       (rise_c),
        .pulse_stb_c_o  (pulse_stb_c),
        .pulse_code_c_o (pulse_code_c),
        .gap_c_o        (gap_c)
    );

    assign data_bit_c = (pulse_code_c == PULSE_ONE);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        consumed_d  = consumed_q;
        shift_d     = shift_q;
        rgb_d       = rgb_q;
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        bit_error_d = 1'b0;

        case (state_q)
            SYNC: begin
                if (gap_c) state_d = IDLE;
            end
            IDLE: begin
                bit_cnt_d  = '0;
                consumed_d = 1'b0;
                if (rise_c) state_d = HIGH;
            end
            HIGH: begin
                if (pulse_stb_c) begin
                    state_d = LOW;
                    if (pulse_code_c == PULSE_ERROR) begin
                        state_d     = SYNC;
                        bit_error_d = 1'b1;
                        bit_cnt_d   = '0;
                        consumed_d  = 1'b0;
                    end else if (pulse_code_c != PULSE_GLITCH && !consumed_q) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            rgb_d      = wire_to_rgb({shift_q, data_bit_c});
                            valid_d    = 1'b1;
                            consumed_d = 1'b1;
                            bit_cnt_d  = '0;
                        end else begin
                            shift_d   = {shift_q[PIX_W-3:0], data_bit_c};
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
            end
            LOW: begin
                if (rise_c) begin
                    state_d = HIGH;
                end else if (gap_c) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = '0;
                    consumed_d  = 1'b0;
                end
            end
            default: state_d = SYNC;
        endcase

        // Only the part of the frame after our own pixel is passed downstream.
        dout_d = consumed_q & ((state_q == HIGH) | (state_q == LOW)) & din_s;
        busy_d = (state_d == HIGH) | (state_d == LOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SYNC;
            bit_cnt_q   <= '0;
            consumed_q  <= 1'b0;
            shift_q     <= '0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            bit_error_q <= 1'b0;
            busy_q      <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            consumed_q  <= consumed_d;
            shift_q     <= shift_d;
            rgb_q       <= rgb_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            bit_error_q <= bit_error_d;
            busy_q      <= busy_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.rgb_data  = rgb_q;
    assign bus.rgb_valid = valid_q;
    assign bus.frame_end = frame_end_q;
    assign bus.bit_error = bit_error_q;
    assign bus.busy      = busy_q;
    assign bus.dout      = dout_q;

endmodule
